// File: rtl/serial_multibyte_adder.sv
// Byte-serial multi-precision adder: one 8-bit slice per cycle, LSB first, carry held between steps.
// Optional macro SERIAL_ADDER_SUBTRACT_EN adds a 'sub' port (A - B - cin via inverted B and carry).
module serial_multibyte_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic                  cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum_out,
  output logic                  cout,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DN   = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    shadow_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            cout_q;
  logic            ovf_q;
  logic            sub_eff;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [8:0]      byte_sum;
  logic            ovf_now;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign state_dbg = state;

  // b_q already holds the inverted operand when subtracting, so the slice is add-only.
  always_comb begin
    a_byte   = a_q[{cnt_q, 3'b000} +: 8];
    b_byte   = b_q[{cnt_q, 3'b000} +: 8];
    byte_sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
    ovf_now  = (a_q[W-1] == b_q[W-1]) && (byte_sum[7] != a_q[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle that shows done still counts as the finishing cycle, so start is ignored there.
          if (start && !done) begin
            a_q     <= a_in;
            b_q     <= b_in ^ {W{sub_eff}};
            carry_q <= cin ^ sub_eff;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          shadow_q[{cnt_q, 3'b000} +: 8] <= byte_sum[7:0];
          carry_q <= byte_sum[8];
          if (cnt_q == LAST) begin
            cout_q <= byte_sum[8];
            ovf_q  <= ovf_now;
            state  <= DN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DN: begin
          sum_out  <= shadow_q;
          cout     <= cout_q;
          overflow <= ovf_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_multibyte_adder.sv
// Bench for serial_multibyte_adder: random and directed operations checked against a
// full-width arithmetic reference through an expected-result queue.
module tb_serial_multibyte_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          cin = 1'b0;
  logic          sub_v = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum_out;
  logic          cout;
  logic          overflow;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W+1:0] exp_q[$];

  serial_multibyte_adder #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub       (sub_v),
`endif
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .cout      (cout),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on whole operands; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    longint ua, ub, sa, sb, cl, r, t;
    logic co, ov;
    logic [W-1:0] sm;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cl = longint'(c);
    if (!s) begin
      r  = ua + ub + cl;
      co = (r >= (longint'(1) << W));
      t  = sa + sb + cl;
    end else begin
      r  = ua - ub - cl;
      co = (ua >= ub + cl);
      t  = sa - sb - cl;
    end
    sm = W'(r);
    ov = (t > (longint'(1) << (W - 1)) - 1) || (t < -(longint'(1) << (W - 1)));
    return {ov, co, sm};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [W+1:0] e;
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = exp_q.pop_front();
        chk("sum_out", 64'(sum_out), 64'(e[W-1:0]));
        chk("cout", 64'(cout), 64'(e[W]));
        chk("overflow", 64'(overflow), 64'(e[W+1]));
      end
    end
  end

  // driver: issue one op, optionally poke start mid-flight, check latency and busy length
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input bit disturb);
    int lat;
    int bc;
    @(posedge clk);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; sub_v = s; start = 1'b1;
    exp_q.push_back(model(a, b, c, s));
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; cin = 1'($urandom_range(0, 1));
    sub_v = 1'($urandom_range(0, 1));
    bc = busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= NB + 6; k++) begin
      if (disturb && (k == 2 || k == 3)) begin
        start = 1'b1; a_in = $urandom; b_in = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(NB + 1));
    chk("busy_cycles", 64'(bc), 64'(NB + 1));
    chk("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  initial begin : main
    int dn;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b1);

    // start raised only in the done cycle must not be accepted
    start = 1'b1; a_in = $urandom; b_in = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("still_idle", 64'(busy), 64'd0);

    // abort in the second ADD cycle
    @(negedge clk);
    a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum_out), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_ovf", 64'(overflow), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (NB + 4) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    run_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUBTRACT_EN
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 1) ra = {1'b0, {(W-1){1'b1}}};
      if (i % 6 == 2) rb = {1'b1, {(W-1){1'b0}}};
`ifdef SERIAL_ADDER_SUBTRACT_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, 1'($urandom_range(0, 1)), rs, (i % 5 == 0));
    end

    repeat (4) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

endmodule
